l2_axi_responder: RTL and testbench

- AXI-lite-style slave that terminates the CPU's L2-side master port: AW/W/B write channels and AR/R read channels.
- Backs requests with a word-addressed on-chip memory. Reads respond after a configurable latency; writes honour byte strobes.
- Used as the L2/memory endpoint in CPU-with-cache simulation and as the base for the real L2 front-end.
- One outstanding read and one outstanding write at a time. The read and write paths are independent.

---
 rtl/l2_axi_responder_if.sv | 33 +++
 rtl/l2_axi_responder.sv | 192 +++++++++++++++++++
 tb/tb_l2_axi_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_axi_responder_if.sv
// AXI-lite-style channel bundle between the L2-side master port and the memory responder.
// The slave modport is the responder's view; the master modport is the requester's view.
interface l2_axi_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   axi_awaddr;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [XLEN-1:0]   axi_wdata;
  logic [XLEN/8-1:0] axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [XLEN-1:0]   axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [XLEN-1:0]   axi_rdata;
  logic              axi_rvalid;
  logic              axi_rready;

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rdata, axi_rvalid
  );

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rdata, axi_rvalid
  );
endinterface

// File: rtl/l2_axi_responder.sv
// Word-addressed on-chip memory behind an AXI-lite-style slave port.
// Independent read and write FSMs, one outstanding transaction each, all outputs registered.
module l2_axi_responder #(
  parameter int              XLEN       = 32,
  parameter int              MEM_DEPTH  = 1024,
  parameter logic [XLEN-1:0] ADDR_BASE  = '0,
  parameter int              RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_axi_responder_if.slave   axi
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NB    = XLEN / 8;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic       {W_COLLECT, W_RESP}      w_state_e;

  // Byte address to word index; truncation to IDX_W bits is the wrap modulo MEM_DEPTH.
  function automatic logic [IDX_W-1:0] word_idx(input logic [XLEN-1:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  logic [XLEN-1:0] mem [MEM_DEPTH];

  // ---------------- read path ----------------
  r_state_e          r_state, r_state_n;
  logic [IDX_W-1:0]  r_idx, r_idx_n;
  logic [CNT_W-1:0]  r_cnt, r_cnt_n;
  logic              arready_q, arready_n;
  logic              rvalid_q, rvalid_n;
  logic [XLEN-1:0]   rdata_q;
  logic              rd_sample;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r_state_n = r_state;
    r_idx_n   = r_idx;
    r_cnt_n   = r_cnt;
    arready_n = arready_q;
    rvalid_n  = rvalid_q;
    rd_sample = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (axi.axi_arvalid && arready_q) begin
          r_idx_n   = word_idx(axi.axi_araddr);
          r_cnt_n   = CNT_W'(RD_LATENCY - 1);
          arready_n = 1'b0;
          r_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        // A latency of 1 also passes through here with a zero count so data lands one edge after AR.
        if (r_cnt == '0) begin
          rd_sample = 1'b1;
          rvalid_n  = 1'b1;
          r_state_n = R_RESP;
        end else begin
          r_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rvalid_q && axi.axi_rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state   <= r_state_n;
      r_idx     <= r_idx_n;
      r_cnt     <= r_cnt_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      if (rd_sample) rdata_q <= mem[r_idx];
    end
  end

  // ---------------- write path ----------------
  w_state_e          w_state, w_state_n;
  logic              aw_held, aw_held_n;
  logic              w_held, w_held_n;
  logic [IDX_W-1:0]  aw_idx, aw_idx_n;
  logic [XLEN-1:0]   wdata_q, wdata_n;
  logic [NB-1:0]     wstrb_q, wstrb_n;
  logic              awready_q, awready_n;
  logic              wready_q, wready_n;
  logic              bvalid_q, bvalid_n;
  logic              commit;

  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_idx_n  = aw_idx;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    awready_n = awready_q;
    wready_n  = wready_q;
    bvalid_n  = bvalid_q;
    commit    = 1'b0;
    unique case (w_state)
      W_COLLECT: begin
        if (aw_held && w_held) begin
          commit    = 1'b1;
          bvalid_n  = 1'b1;
          w_state_n = W_RESP;
        end else begin
          if (axi.axi_awvalid && awready_q) begin
            aw_held_n = 1'b1;
            aw_idx_n  = word_idx(axi.axi_awaddr);
            awready_n = 1'b0;
          end
          if (axi.axi_wvalid && wready_q) begin
            w_held_n = 1'b1;
            wdata_n  = axi.axi_wdata;
            wstrb_n  = axi.axi_wstrb;
            wready_n = 1'b0;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && axi.axi_bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_state_n = W_COLLECT;
        end
      end
      default: w_state_n = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_COLLECT;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
    end else begin
      w_state   <= w_state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      aw_idx    <= aw_idx_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
    end
  end

  // NOTE: the memory array has no reset; only the control that decides whether to commit is reset.
  // A read sampling the same word on the commit edge sees the old value because both use edge-sampled state.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_q[b]) mem[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;

endmodule

// File: tb/tb_l2_axi_responder.sv
// Directed bench for l2_axi_responder: handshake timing, byte strobes, wrap, stalls, collision and reset abort.
module tb_l2_axi_responder;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] rd;

  l2_axi_responder_if #(.XLEN(32)) bus ();

  l2_axi_responder #(
    .XLEN(32), .MEM_DEPTH(1024), .ADDR_BASE(32'h0), .RD_LATENCY(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bus.axi_awaddr  = addr;
    bus.axi_wdata   = data;
    bus.axi_wstrb   = strb;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid  = 1'b1;
    bus.axi_bready  = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    n = 0;
    while (!bus.axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid", {31'b0, bus.axi_bvalid}, 32'd1);
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    bus.axi_araddr  = addr;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b1;
    tick();
    bus.axi_arvalid = 1'b0;
    n = 0;
    while (!bus.axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    check("rd_rvalid", {31'b0, bus.axi_rvalid}, 32'd1);
    data = bus.axi_rdata;
    tick();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.axi_awaddr  = '0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wdata   = '0;
    bus.axi_wstrb   = '0;
    bus.axi_wvalid  = 1'b0;
    bus.axi_bready  = 1'b0;
    bus.axi_araddr  = '0;
    bus.axi_arvalid = 1'b0;
    bus.axi_rready  = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_arready", {31'b0, bus.axi_arready}, 32'd1);
    check("rst_awready", {31'b0, bus.axi_awready}, 32'd1);
    check("rst_wready",  {31'b0, bus.axi_wready},  32'd1);
    check("rst_rvalid",  {31'b0, bus.axi_rvalid},  32'd0);
    check("rst_bvalid",  {31'b0, bus.axi_bvalid},  32'd0);
    check("rst_rdata",   bus.axi_rdata,            32'h0);
    rst_n = 1'b1;
    tick();

    // AW and W together, then read back with exact latency
    bus.axi_awaddr  = 32'h10;
    bus.axi_wdata   = 32'hDEADBEEF;
    bus.axi_wstrb   = 4'hF;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid  = 1'b1;
    bus.axi_bready  = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    check("w1_bvalid_hs",  {31'b0, bus.axi_bvalid},  32'd0);
    check("w1_awready_hs", {31'b0, bus.axi_awready}, 32'd0);
    check("w1_wready_hs",  {31'b0, bus.axi_wready},  32'd0);
    tick();
    check("w1_bvalid_set", {31'b0, bus.axi_bvalid},  32'd1);
    tick();
    check("w1_bvalid_clr", {31'b0, bus.axi_bvalid},  32'd0);
    check("w1_awready_re", {31'b0, bus.axi_awready}, 32'd1);
    check("w1_wready_re",  {31'b0, bus.axi_wready},  32'd1);

    bus.axi_araddr  = 32'h10;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b1;
    tick();
    bus.axi_arvalid = 1'b0;
    check("r1_arready_hs", {31'b0, bus.axi_arready}, 32'd0);
    check("r1_rvalid_e0",  {31'b0, bus.axi_rvalid},  32'd0);
    tick();
    check("r1_rvalid_e1",  {31'b0, bus.axi_rvalid},  32'd0);
    tick();
    check("r1_rvalid_e2",  {31'b0, bus.axi_rvalid},  32'd1);
    check("r1_rdata",      bus.axi_rdata,            32'hDEADBEEF);
    tick();
    check("r1_rvalid_clr", {31'b0, bus.axi_rvalid},  32'd0);
    check("r1_arready_re", {31'b0, bus.axi_arready}, 32'd1);

    // W three cycles before AW
    bus.axi_wdata  = 32'h0BADF00D;
    bus.axi_wstrb  = 4'hF;
    bus.axi_wvalid = 1'b1;
    tick();
    bus.axi_wvalid = 1'b0;
    check("wfirst_wready", {31'b0, bus.axi_wready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("wfirst_awready_wait", {31'b0, bus.axi_awready}, 32'd1);
      check("wfirst_bvalid_wait",  {31'b0, bus.axi_bvalid},  32'd0);
      if (i < 2) tick();
    end
    bus.axi_awaddr  = 32'h30;
    bus.axi_awvalid = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    check("wfirst_awready_hs", {31'b0, bus.axi_awready}, 32'd0);
    check("wfirst_bvalid_hs",  {31'b0, bus.axi_bvalid},  32'd0);
    tick();
    check("wfirst_bvalid_set", {31'b0, bus.axi_bvalid},  32'd1);
    tick();
    check("wfirst_bvalid_clr", {31'b0, bus.axi_bvalid},  32'd0);
    do_read(32'h30, rd);
    check("wfirst_rdata", rd, 32'h0BADF00D);

    // Byte strobes, including the all-zero strobe
    do_write(32'h20, 32'h11223344, 4'hF);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101);
    do_read(32'h20, rd);
    check("strb_0101", rd, 32'h11BB33DD);
    do_write(32'h22, 32'hFFFFFFFF, 4'b0000);
    do_read(32'h20, rd);
    check("strb_0000", rd, 32'h11BB33DD);

    // R channel stalled by rready=0 for five cycles
    bus.axi_araddr  = 32'h20;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b0;
    tick();
    bus.axi_araddr  = 32'h10;
    tick();
    tick();
    check("stall_rvalid_on", {31'b0, bus.axi_rvalid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rvalid",  {31'b0, bus.axi_rvalid},  32'd1);
      check("stall_rdata",   bus.axi_rdata,            32'h11BB33DD);
      check("stall_arready", {31'b0, bus.axi_arready}, 32'd0);
    end
    bus.axi_arvalid = 1'b0;
    bus.axi_rready  = 1'b1;
    tick();
    check("stall_rvalid_clr", {31'b0, bus.axi_rvalid},  32'd0);
    check("stall_arready_re", {31'b0, bus.axi_arready}, 32'd1);

    // Address wrap modulo MEM_DEPTH words
    do_write(32'h10 + 32'd4096, 32'hCAFEF00D, 4'hF);
    do_read(32'h10, rd);
    check("wrap_rdata", rd, 32'hCAFEF00D);

    // Read completes while B is held back by bready=0
    bus.axi_bready  = 1'b0;
    bus.axi_awaddr  = 32'h40;
    bus.axi_wdata   = 32'h5555AAAA;
    bus.axi_wstrb   = 4'hF;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid  = 1'b1;
    bus.axi_araddr  = 32'h20;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    bus.axi_arvalid = 1'b0;
    tick();
    check("conc_bvalid_e1", {31'b0, bus.axi_bvalid}, 32'd1);
    tick();
    check("conc_rvalid_e2", {31'b0, bus.axi_rvalid}, 32'd1);
    check("conc_rdata",     bus.axi_rdata,           32'h11BB33DD);
    tick();
    check("conc_rvalid_clr", {31'b0, bus.axi_rvalid},  32'd0);
    check("conc_bvalid_held", {31'b0, bus.axi_bvalid}, 32'd1);
    check("conc_awready_held", {31'b0, bus.axi_awready}, 32'd0);
    bus.axi_bready = 1'b1;
    tick();
    check("conc_bvalid_clr", {31'b0, bus.axi_bvalid}, 32'd0);
    do_read(32'h40, rd);
    check("conc_wdata", rd, 32'h5555AAAA);

    // Commit and read sample on the same edge to the same word
    do_write(32'h50, 32'h12345678, 4'hF);
    bus.axi_araddr  = 32'h50;
    bus.axi_arvalid = 1'b1;
    bus.axi_rready  = 1'b1;
    bus.axi_bready  = 1'b1;
    tick();
    bus.axi_arvalid = 1'b0;
    bus.axi_awaddr  = 32'h50;
    bus.axi_wdata   = 32'h87654321;
    bus.axi_wstrb   = 4'hF;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid  = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    tick();
    check("coll_rvalid", {31'b0, bus.axi_rvalid}, 32'd1);
    check("coll_bvalid", {31'b0, bus.axi_bvalid}, 32'd1);
    check("coll_old",    bus.axi_rdata,           32'h12345678);
    tick();
    do_read(32'h50, rd);
    check("coll_new", rd, 32'h87654321);

    // Reset between AW and W handshakes
    do_write(32'h60, 32'h0F0F0F0F, 4'hF);
    bus.axi_awaddr  = 32'h60;
    bus.axi_awvalid = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    check("rstw_awready_hs", {31'b0, bus.axi_awready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstw_awready", {31'b0, bus.axi_awready}, 32'd1);
    check("rstw_wready",  {31'b0, bus.axi_wready},  32'd1);
    check("rstw_arready", {31'b0, bus.axi_arready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    bus.axi_wdata  = 32'hBAD0BAD0;
    bus.axi_wstrb  = 4'hF;
    bus.axi_wvalid = 1'b1;
    tick();
    bus.axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_bvalid", {31'b0, bus.axi_bvalid}, 32'd0);
      tick();
    end
    bus.axi_awaddr  = 32'h70;
    bus.axi_awvalid = 1'b1;
    tick();
    bus.axi_awvalid = 1'b0;
    tick();
    check("rstw_bvalid_after", {31'b0, bus.axi_bvalid}, 32'd1);
    tick();
    do_read(32'h60, rd);
    check("rstw_mem_kept", rd, 32'h0F0F0F0F);
    do_read(32'h70, rd);
    check("rstw_new_write", rd, 32'hBAD0BAD0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
